// File: rtl/hmc_pkg.sv
// Shared hmc-6502 types and constants.
// Branch sequencer state encoding and reset vector.
package hmc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD_LO,
    FIX_HI
  } bseq_state_t;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'hFFFC;

endpackage

// File: rtl/branch_pc_seq_if.sv
// PC sequencer control/status bundle.
// The master drives the controls; the slave is the sequencer.
interface branch_pc_seq_if;

  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        pc_inc;
  logic        start;
  logic [7:0]  p;
  logic [7:0]  op_flags;
  logic        branch_polarity;
  logic [7:0]  offset;
  logic [15:0] pc;
  logic        busy;
  logic        taken;
  logic        page_cross;
  logic        done;

  modport master (
    output pc_load, pc_load_val, pc_inc, start,
    output p, op_flags, branch_polarity, offset,
    input  pc, busy, taken, page_cross, done
  );

  modport slave (
    input  pc_load, pc_load_val, pc_inc, start,
    input  p, op_flags, branch_polarity, offset,
    output pc, busy, taken, page_cross, done
  );

endinterface

// File: rtl/adderc.sv
// Generic W-bit adder with carry in and carry out.
module adderc #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);

  logic [W:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b}
                + {{W{1'b0}}, i_cin};
  assign o_s    = w_sum[W-1:0];
  assign o_cout = w_sum[W];

endmodule

// File: rtl/inc.sv
// Generic W-bit incrementer, wraps to zero.
module inc #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  assign o_y = i_a + W'(1);

endmodule

// File: rtl/branch_pc_seq.sv
// Program-counter sequencer with 6502 relative-branch timing.
// Low byte fixed first; high byte fixed a cycle later on page cross.
module branch_pc_seq
  import hmc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  branch_pc_seq_if.slave    bus
);

  bseq_state_t r_state, w_nstate;

  logic [15:0] r_pc, w_npc;
  logic [7:0]  r_off, w_noff;
  logic        r_taken, w_ntaken;
  logic        r_pcx, w_npcx;
  logic        r_done, w_ndone;

  logic [7:0]  w_lo_sum;
  logic        w_lo_c;
  logic [15:0] w_pc_inc;
  logic [7:0]  w_hi_k;
  logic [7:0]  w_hi_fix;
  logic        w_cond;
  logic        w_cross;

  adderc #(.W(8)) u_lo_add (
    .i_a    (r_pc[7:0]),
    .i_b    (r_off),
    .i_cin  (1'b0),
    .o_s    (w_lo_sum),
    .o_cout (w_lo_c)
  );

  inc #(.W(16)) u_pc_inc (
    .i_a (r_pc),
    .o_y (w_pc_inc)
  );

  // Sign of the offset picks +1 or -1 for the high byte
  assign w_hi_k   = r_off[7] ? 8'hFF : 8'h01;
  assign w_hi_fix = r_pc[15:8] + w_hi_k;

  assign w_cond  = bus.branch_polarity
                 ^ (|(bus.op_flags & bus.p));
  assign w_cross = w_lo_c ^ r_off[7];

  always_comb begin
    w_nstate = r_state;
    w_npc    = r_pc;
    w_noff   = r_off;
    w_ntaken = r_taken;
    w_npcx   = r_pcx;
    w_ndone  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.pc_load) begin
          w_npc = bus.pc_load_val;
        end else if (bus.start) begin
          w_noff   = bus.offset;
          w_ntaken = w_cond;
          w_npcx   = 1'b0;
          if (w_cond) w_nstate = ADD_LO;
          else        w_ndone  = 1'b1;
        end else if (bus.pc_inc) begin
          w_npc = w_pc_inc;
        end
      end
      ADD_LO: begin
        w_npc  = {r_pc[15:8], w_lo_sum};
        w_npcx = w_cross;
        if (w_cross) begin
          w_nstate = FIX_HI;
        end else begin
          w_nstate = IDLE;
          w_ndone  = 1'b1;
        end
      end
      FIX_HI: begin
        w_npc    = {w_hi_fix, r_pc[7:0]};
        w_nstate = IDLE;
        w_ndone  = 1'b1;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_off   <= 8'h00;
      r_taken <= 1'b0;
      r_pcx   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      r_off   <= w_noff;
      r_taken <= w_ntaken;
      r_pcx   <= w_npcx;
      r_done  <= w_ndone;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.busy       = (r_state != IDLE);
  assign bus.taken      = r_taken;
  assign bus.page_cross = r_pcx;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_branch_pc_seq.sv
// Directed bench for branch_pc_seq.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_branch_pc_seq;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  branch_pc_seq_if bus ();

  branch_pc_seq #(.RESET_PC(16'hFFFC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic load_pc(input logic [15:0] v);
    bus.pc_load     = 1'b1;
    bus.pc_load_val = v;
    tick();
    bus.pc_load     = 1'b0;
  endtask

  task automatic go(input logic [7:0] p,
                    input logic [7:0] fl,
                    input logic       pol,
                    input logic [7:0] off);
    bus.p               = p;
    bus.op_flags        = fl;
    bus.branch_polarity = pol;
    bus.offset          = off;
    bus.start           = 1'b1;
    tick();
    bus.start           = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.pc_load         = 1'b0;
    bus.pc_load_val     = 16'h0000;
    bus.pc_inc          = 1'b0;
    bus.start           = 1'b0;
    bus.p               = 8'h00;
    bus.op_flags        = 8'h00;
    bus.branch_polarity = 1'b0;
    bus.offset          = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_pc", bus.pc, 16'hFFFC);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_taken", 16'(bus.taken), 16'h0);
    chk("rst_px", 16'(bus.page_cross), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);

    // Load / increment
    load_pc(16'h1234);
    chk("load", bus.pc, 16'h1234);
    bus.pc_inc = 1'b1;
    tick(); tick(); tick();
    bus.pc_inc = 1'b0;
    chk("inc3", bus.pc, 16'h1237);
    load_pc(16'hFFFF);
    bus.pc_inc = 1'b1;
    tick();
    bus.pc_inc = 1'b0;
    chk("inc_wrap", bus.pc, 16'h0000);

    // Not taken
    load_pc(16'h0200);
    go(8'h00, 8'h02, 1'b0, 8'h10);
    chk("nt_pc", bus.pc, 16'h0200);
    chk("nt_taken", 16'(bus.taken), 16'h0);
    chk("nt_done", 16'(bus.done), 16'h1);
    chk("nt_busy", 16'(bus.busy), 16'h0);
    tick();
    chk("nt_done_end", 16'(bus.done), 16'h0);

    // Polarity inverts: flag clear + pol=1 is taken, same page
    load_pc(16'h0210);
    go(8'h00, 8'h02, 1'b1, 8'h10);
    chk("pol_taken", 16'(bus.taken), 16'h1);
    tick();
    chk("pol_pc", bus.pc, 16'h0220);
    tick();

    // Taken, same page
    load_pc(16'h0210);
    go(8'h02, 8'h02, 1'b0, 8'h10);
    chk("sp_busy0", 16'(bus.busy), 16'h1);
    chk("sp_taken", 16'(bus.taken), 16'h1);
    chk("sp_done0", 16'(bus.done), 16'h0);
    chk("sp_pc0", bus.pc, 16'h0210);
    tick();
    chk("sp_pc1", bus.pc, 16'h0220);
    chk("sp_busy1", 16'(bus.busy), 16'h0);
    chk("sp_done1", 16'(bus.done), 16'h1);
    chk("sp_px", 16'(bus.page_cross), 16'h0);
    tick();
    chk("sp_done2", 16'(bus.done), 16'h0);
    chk("sp_hold", 16'(bus.taken), 16'h1);

    // Forward cross, pc_inc held while busy must be ignored
    load_pc(16'h02F0);
    go(8'h02, 8'h02, 1'b0, 8'h20);
    bus.pc_inc = 1'b1;
    chk("fc_busy0", 16'(bus.busy), 16'h1);
    tick();
    chk("fc_pc1", bus.pc, 16'h0210);
    chk("fc_busy1", 16'(bus.busy), 16'h1);
    chk("fc_px", 16'(bus.page_cross), 16'h1);
    chk("fc_done1", 16'(bus.done), 16'h0);
    tick();
    bus.pc_inc = 1'b0;
    chk("fc_pc2", bus.pc, 16'h0310);
    chk("fc_busy2", 16'(bus.busy), 16'h0);
    chk("fc_done2", 16'(bus.done), 16'h1);
    tick();

    // Address space wrap
    load_pc(16'hFFF0);
    go(8'h02, 8'h02, 1'b0, 8'h20);
    tick();
    chk("wr_pc1", bus.pc, 16'hFF10);
    tick();
    chk("wr_pc2", bus.pc, 16'h0010);
    tick();

    // Backward cross
    load_pc(16'h0205);
    go(8'h02, 8'h02, 1'b0, 8'hF0);
    tick();
    chk("bc_pc1", bus.pc, 16'h02F5);
    chk("bc_px", 16'(bus.page_cross), 16'h1);
    tick();
    chk("bc_pc2", bus.pc, 16'h01F5);
    chk("bc_done", 16'(bus.done), 16'h1);
    // Restart while done is high: not taken clears page_cross
    go(8'h00, 8'h02, 1'b0, 8'h10);
    chk("rs_px", 16'(bus.page_cross), 16'h0);
    chk("rs_done", 16'(bus.done), 16'h1);
    tick();

    // Backward, same page
    load_pc(16'h0220);
    go(8'h02, 8'h02, 1'b0, 8'hF0);
    tick();
    chk("bs_pc", bus.pc, 16'h0210);
    chk("bs_px", 16'(bus.page_cross), 16'h0);
    chk("bs_busy", 16'(bus.busy), 16'h0);
    tick();

    // Reset while in FIX_HI
    load_pc(16'h02F0);
    go(8'h02, 8'h02, 1'b0, 8'h20);
    tick();
    chk("rf_busy", 16'(bus.busy), 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rf_pc", bus.pc, 16'hFFFC);
    chk("rf_busy2", 16'(bus.busy), 16'h0);
    chk("rf_taken", 16'(bus.taken), 16'h0);
    chk("rf_px", 16'(bus.page_cross), 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rf_done", 16'(bus.done), 16'h0);
      tick();
    end
    chk("rf_pc_end", bus.pc, 16'hFFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
